// File: rtl/wide_word_serializer.sv
// Wide-word transmit serializer: captures a WIDTH-bit word with per-bit override
// and streams it LSB beat first as BEAT-bit beats over valid/ready.
module wide_word_serializer #(
  parameter int WIDTH = 128,
  parameter int BEAT  = 32,
  localparam int BEATS = WIDTH / BEAT,
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] ovr_mask,
  input  logic [WIDTH-1:0] ovr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BEAT-1:0]  out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] word;
  logic [IW-1:0]    idx;
  logic             at_last;
  logic             beat_fire;
  logic             capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // load_ready is deliberately combinational from out_ready so the next word
  // can be captured on the same edge that retires the last beat.
  always_comb begin
    state_nx   = state;
    at_last    = (idx == LAST_IDX);
    beat_fire  = 1'b0;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nx = SEND;
      end
      SEND: begin
        out_valid  = 1'b1;
        busy       = 1'b1;
        out_last   = at_last;
        beat_fire  = out_ready;
        load_ready = at_last & out_ready;
        if (out_ready && at_last && !load_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    capture = load_valid & load_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      idx        <= '0;
      words_sent <= '0;
    end else begin
      if (capture) begin
        word <= (load_data & ~ovr_mask) | (ovr_data & ovr_mask);
        idx  <= '0;
      end else if (beat_fire && !at_last) begin
        idx <= idx + IW'(1);
      end
      if (beat_fire && at_last) words_sent <= words_sent + 16'd1;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (idx == IW'(i)) out_data = word[i*BEAT +: BEAT];
    end
  end

  assign out_idx = idx;

endmodule

// File: tb/tb_wide_word_serializer.sv
// Self-checking bench for wide_word_serializer: directed and random words checked
// against a beat-list reference model, plus a counter-wrap run on a one-beat instance.
module tb_wide_word_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lv = 1'b0, lr, ov, ordy = 1'b0, olast, busy;
  logic [127:0] ld = '0, om = '0, od = '0;
  logic [31:0]  odat;
  logic [1:0]   oidx;
  logic [15:0]  ws;

  logic         lv2 = 1'b0, lr2, ov2, ordy2 = 1'b0, olast2, busy2;
  logic [7:0]   ld2 = '0, om2 = '0, od2 = '0, odat2;
  logic [0:0]   oidx2;
  logic [15:0]  ws2;

  int total = 0;
  int bad   = 0;
  int exp_ws = 0;

  always #5 clk = ~clk;

  wide_word_serializer #(.WIDTH(128), .BEAT(32)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_ready(lr),
    .load_data(ld), .ovr_mask(om), .ovr_data(od),
    .out_valid(ov), .out_ready(ordy), .out_data(odat), .out_idx(oidx),
    .out_last(olast), .busy(busy), .words_sent(ws)
  );

  wide_word_serializer #(.WIDTH(8), .BEAT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv2), .load_ready(lr2),
    .load_data(ld2), .ovr_mask(om2), .ovr_data(od2),
    .out_valid(ov2), .out_ready(ordy2), .out_data(odat2), .out_idx(oidx2),
    .out_last(olast2), .busy(busy2), .words_sent(ws2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] cap(input logic [127:0] d, m, o);
    return (d & ~m) | (o & m);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present a word while the serializer is idle; it is captured on the next edge.
  task automatic load(input logic [127:0] d, m, o);
    @(negedge clk);
    lv = 1'b1; ld = d; om = m; od = o; ordy = 1'($urandom_range(1));
    #1;
    chk("load_ready_idle", lr, 1);
    chk("busy_idle", busy, 0);
    chk("valid_idle", ov, 0);
  endtask

  // Stream one held word; optionally chain the next word onto the last beat.
  task automatic drain(input logic [127:0] w, input int pready, input bit chain,
                       input logic [127:0] nd, nm, no, output int cycles);
    int k = 0;
    cycles = 0;
    while (k < 4 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      ordy = ($urandom_range(99) < pready);
      lv   = chain || (k != 3 && $urandom_range(1) == 1);
      if (chain && k == 3) begin
        ld = nd; om = nm; od = no;
      end else begin
        ld = rnd128(); om = rnd128(); od = rnd128();
      end
      #1;
      chk("out_valid", ov, 1);
      chk("out_data", odat, w[k*32 +: 32]);
      chk("out_idx", oidx, k);
      chk("out_last", olast, k == 3);
      chk("busy", busy, 1);
      chk("load_ready_send", lr, (k == 3) && ordy);
      chk("words_sent_mid", ws, exp_ws[15:0]);
      if (ordy) k++;
    end
    chk("drain_done", k, 4);
    exp_ws++;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    lv = 1'b0;
    #1;
    chk("idle_valid", ov, 0);
    chk("idle_busy", busy, 0);
    chk("idle_load_ready", lr, 1);
    chk("idle_last", olast, 0);
    chk("idle_words_sent", ws, exp_ws[15:0]);
  endtask

  initial begin
    logic [127:0] a, b, d, m, o, cur;
    int cyc, cyc2;
    bit holding, chain;

    // Reset state
    #12;
    chk("rst_valid", ov, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_ready", lr, 1);
    chk("rst_words_sent", ws, 0);
    chk("rst_data", odat, 0);
    chk("rst_last", olast, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single high override bit clears bit 127 only
    d = '1; m = 128'd1 << 127; o = '0;
    load(d, m, o);
    chk("ovr_bit_model", cap(d, m, o) >> 96, 128'h7FFF_FFFF);
    drain(cap(d, m, o), 100, 1'b0, '0, '0, '0, cyc);
    idle_chk();

    // Backpressure on beat 1, stray load requests must be ignored
    a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    load(a, '0, '0);
    @(negedge clk);
    lv = 1'b0; ordy = 1'b1;
    #1;
    chk("bp_beat0", odat, 32'h7654_3210);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ordy = 1'b0; lv = 1'b1; ld = rnd128(); om = rnd128(); od = rnd128();
      #1;
      chk("bp_data", odat, 32'hFEDC_BA98);
      chk("bp_idx", oidx, 1);
      chk("bp_load_ready", lr, 0);
      chk("bp_last", olast, 0);
    end
    @(negedge clk);
    lv = 1'b0; ordy = 1'b1;
    #1;
    chk("bp_release", odat, 32'hFEDC_BA98);
    repeat (2) @(negedge clk);
    #1;
    chk("bp_beat3", odat, 32'h0123_4567);
    chk("bp_beat3_last", olast, 1);
    exp_ws++;
    idle_chk();

    // Back-to-back words A then B with no bubble
    a = rnd128(); b = rnd128();
    load(a, '0, '0);
    drain(a, 100, 1'b1, b, '0, '0, cyc);
    drain(b, 100, 1'b0, '0, '0, '0, cyc2);
    chk("b2b_cycles", cyc + cyc2, 8);
    idle_chk();

    // Full override
    load('0, '1, {4{32'h5555_5555}});
    drain({4{32'h5555_5555}}, 100, 1'b0, '0, '0, '0, cyc);
    idle_chk();

    // Random words, random backpressure, random chaining
    holding = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if (!holding) begin
        d = rnd128(); m = rnd128(); o = rnd128();
        load(d, m, o);
        cur = cap(d, m, o);
      end
      chain = (n < 24) && ($urandom_range(1) == 1);
      d = rnd128(); m = rnd128(); o = rnd128();
      drain(cur, 40 + $urandom_range(60), chain, d, m, o, cyc);
      if (chain) begin
        cur = cap(d, m, o);
        holding = 1'b1;
      end else begin
        idle_chk();
        holding = 1'b0;
      end
    end

    // Reset mid-stream after beat 1 accepted
    load(rnd128(), '0, '0);
    repeat (2) begin
      @(negedge clk);
      lv = 1'b0; ordy = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", ov, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_words_sent", ws, 0);
    chk("mrst_load_ready", lr, 1);
    chk("mrst_data", odat, 0);
    exp_ws = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", ov, 0);
      chk("post_rst_load_ready", lr, 1);
    end

    // Counter wrap on a one-beat instance
    begin
      int issued = 0, sent = 0, wc = 0;
      logic [7:0] q[$];
      ordy2 = 1'b1;
      while (sent < 65536 && wc < 70000) begin
        @(negedge clk);
        wc++;
        lv2 = (issued < 65536);
        ld2 = 8'(issued * 7 + 3);
        #1;
        if (ov2) begin
          if (sent == 65535) chk("ws_ffff", ws2, 16'hFFFF);
          if (sent % 4096 == 0) begin
            chk("narrow_data", odat2, (q.size() > 0) ? q[0] : 8'hxx);
            chk("narrow_last", olast2, 1);
            chk("narrow_ws", ws2, sent % 65536);
          end
          if (q.size() > 0) void'(q.pop_front());
          sent++;
        end
        if (lv2 && lr2) begin
          q.push_back(ld2);
          issued++;
        end
      end
      chk("wrap_count", sent, 65536);
      @(negedge clk);
      lv2 = 1'b0;
      #1;
      chk("ws_wrap", ws2, 0);
      chk("narrow_idle", ov2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
